// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared LFSR constants and checker state encoding
package lfsr_checker_pkg;

   localparam int          DEF_WIDTH = 16;
   localparam logic [15:0] DEF_POLY  = 16'hD008;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

endpackage

// File: rtl/lfsr_ref_step.sv
// rtl/lfsr_ref_step.sv - one Fibonacci LFSR step: predicted bit and next register
module lfsr_ref_step
   import lfsr_checker_pkg::*;
#(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = DEF_POLY
) (
   input  logic [WIDTH-1:0] s,
   input  logic             d,
   input  logic             use_d,
   output logic             pred,
   output logic [WIDTH-1:0] next
);

   always_comb begin
      pred = ^(s & POLY);
      // use_d selects self-synchronous shifting versus a free-running reference
      next = {s[WIDTH-2:0], use_d ? d : pred};
   end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with lock FSM and saturating counters
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int               WIDTH        = DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY         = DEF_POLY,
   parameter int               LOCK_COUNT   = 32,
   parameter int               UNLOCK_COUNT = 8,
   parameter int               CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 d,
   input  logic                 clr_cnt,
   output logic                 locked,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] bit_count,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam int FW = $clog2(WIDTH + 1);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int XW = $clog2(UNLOCK_COUNT + 1);

   state_t          state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, step_next;
   logic [FW-1:0]   fill_cnt, fill_nxt;
   logic [MW-1:0]   match_cnt, match_nxt;
   logic [XW-1:0]   miss_cnt, miss_nxt;
   logic            pred, hit, count_evt, miss_evt;

   lfsr_ref_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
      .s     (shreg),
      .d     (d),
      .use_d (state != LOCKED),
      .pred  (pred),
      .next  (step_next)
   );

   assign hit    = (d == pred);
   assign locked = (state == LOCKED);

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      fill_nxt  = fill_cnt;
      match_nxt = match_cnt;
      miss_nxt  = miss_cnt;
      count_evt = 1'b0;
      miss_evt  = 1'b0;
      if (ce) begin
         shreg_nxt = step_next;
         case (state)
            FILL: begin
               fill_nxt = fill_cnt + 1'b1;
               if (fill_cnt == FW'(WIDTH - 1)) begin
                  state_nxt = LOCKING;
                  match_nxt = '0;
               end
            end
            LOCKING: begin
               // an all-zero history predicts 0 forever, so a dead link must never count as a match
               if (hit && (shreg != '0)) begin
                  match_nxt = match_cnt + 1'b1;
                  if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                     state_nxt = LOCKED;
                     miss_nxt  = '0;
                  end
               end else begin
                  match_nxt = '0;
               end
            end
            LOCKED: begin
               count_evt = 1'b1;
               if (!hit) begin
                  miss_evt = 1'b1;
                  miss_nxt = miss_cnt + 1'b1;
                  if (miss_cnt == XW'(UNLOCK_COUNT - 1)) begin
                     state_nxt = FILL;
                     fill_nxt  = '0;
                  end
               end else begin
                  miss_nxt = '0;
               end
            end
            default: state_nxt = FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         shreg     <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         error     <= 1'b0;
         bit_count <= '0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         fill_cnt  <= fill_nxt;
         match_cnt <= match_nxt;
         miss_cnt  <= miss_nxt;
         error     <= miss_evt;
         if (clr_cnt) begin
            bit_count <= '0;
            err_count <= '0;
         end else begin
            if (count_evt && !(&bit_count)) bit_count <= bit_count + 1'b1;
            if (miss_evt && !(&err_count))  err_count <= err_count + 1'b1;
         end
      end
   end

endmodule
